mem_stage_ctrl: RTL and testbench

- Sequences Memory-stage data accesses against a variable-latency data memory using a req/ready + rvalid handshake.
- Stalls the F/D/E/M pipeline registers while an access is outstanding.
- Injects bubbles into the MEM/WB register during stall cycles, so Writeback never sees a partial or repeated access.
- Presents the returned load data to MEM/WB in the single cycle the pipeline is released.

---
 rtl/mem_stage_ctrl.sv | 155 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//
// Memory-stage access sequencer for a variable-latency data memory.
// A load or store seen in the M stage is registered into a request, presented
// with a req/ready handshake and (for loads) completed by rvalid. While the
// access is outstanding the F/D/E/M registers are frozen and MEM/WB receives
// bubbles. The pipeline is released for exactly one cycle (DONE), which is
// when MEM/WB captures ReadDataM. An access that does not complete within
// TIMEOUT_CYCLES cycles of REQ+WAIT is abandoned and reported as a fault.
//
// Ports
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   MemReqM           M-stage instruction is a load/store (held while stalled)
//   MemWriteM         1 = store, 0 = load
//   AddrM, WriteDataM byte address and store data from the M stage
//   mem_req/mem_we    request valid / request is a write
//   mem_addr/mem_wdata registered request address / store data
//   mem_ready         memory accepts the request this cycle
//   mem_rvalid/rdata  load return
//   StallM            freeze F/D/E/M pipeline registers
//   FlushW            insert a bubble into MEM/WB
//   ReadDataM         load data for MEM/WB (meaningful only in DONE)
//   FaultM            one-cycle pulse in DONE after a timeout
//   FaultSticky       set by any timeout, cleared only by reset
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        FlushW,
  output logic [31:0] ReadDataM,
  output logic        FaultM,
  output logic        FaultSticky
);

  localparam int               CNT_W   = 16;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] to_cnt;
  logic             start;
  logic             capture;
  logic             timeout;

  always_comb begin
    state_nxt = state;
    StallM    = 1'b0;
    FlushW    = 1'b0;
    mem_req   = 1'b0;
    start     = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        // Mealy stall: the instruction must not leave M in the cycle it is
        // first seen. Gated by RST_N so reset forces every output quiet.
        if (MemReqM && RST_N) begin
          StallM    = 1'b1;
          FlushW    = 1'b1;
          start     = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        StallM  = 1'b1;
        FlushW  = 1'b1;
        // An accepted store is complete; an accepted load still needs its
        // data, so on the last allowed cycle only a store beats the timeout.
        if (mem_ready && mem_we) begin
          state_nxt = S_DONE;
        end else if (to_cnt == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = S_DONE;
        end else if (mem_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        StallM = 1'b1;
        FlushW = 1'b1;
        if (mem_rvalid) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end else if (to_cnt == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Pipeline advances; a MemReqM still high here is the completing
        // instruction itself and is deliberately ignored.
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      ReadDataM   <= '0;
      FaultM      <= 1'b0;
      FaultSticky <= 1'b0;
      to_cnt      <= '0;
    end else begin
      state  <= state_nxt;
      FaultM <= timeout;
      if (timeout) begin
        FaultSticky <= 1'b1;
        ReadDataM   <= '0;
      end else if (capture) begin
        ReadDataM <= mem_rdata;
      end
      // Request fields are only loaded on entry to REQ, so they stay
      // constant for the whole handshake.
      if (start) begin
        mem_we    <= MemWriteM;
        mem_addr  <= AddrM;
        mem_wdata <= WriteDataM;
        to_cnt    <= '0;
      end else if (state == S_REQ || state == S_WAIT) begin
        to_cnt <= to_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
//
// Directed bench for mem_stage_ctrl. Each transaction is described by its
// kind, address/data and the memory's response times; a transaction-level
// model turns these into the number of REQ and WAIT cycles and the fault
// outcome, from which the expected per-cycle outputs follow. One compare
// process checks the DUT against those expectations on every falling edge;
// literal checks pin stall lengths, captured data and fault behaviour.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] AddrM;
  logic [31:0] WriteDataM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        StallM;
  logic        FlushW;
  logic [31:0] ReadDataM;
  logic        FaultM;
  logic        FaultSticky;

  always #5 CLK = ~CLK;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .MemReqM    (MemReqM),
    .MemWriteM  (MemWriteM),
    .AddrM      (AddrM),
    .WriteDataM (WriteDataM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .StallM     (StallM),
    .FlushW     (FlushW),
    .ReadDataM  (ReadDataM),
    .FaultM     (FaultM),
    .FaultSticky(FaultSticky)
  );

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle
  bit          chk_en = 1'b0;
  bit          e_stall, e_flush, e_req, e_fm, e_we;
  logic [31:0] e_addr, e_wdata;
  logic [31:0] rd_model = 32'h0;
  bit          fs_model = 1'b0;

  // Observation counters, written only by the compare process
  int          stall_total = 0;
  int          fault_total = 0;
  bit          prev_stall  = 1'b0;
  logic [31:0] wb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("StallM", 32'(StallM), 32'(e_stall));
      chk("FlushW", 32'(FlushW), 32'(e_flush));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("FaultM", 32'(FaultM), 32'(e_fm));
      chk("FaultSticky", 32'(FaultSticky), 32'(fs_model));
      chk("ReadDataM", ReadDataM, rd_model);
      if (e_req) begin
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
      end
      stall_total <= stall_total + (StallM ? 1 : 0);
      fault_total <= fault_total + (FaultM ? 1 : 0);
      if (prev_stall && !StallM) wb_q.push_back(ReadDataM);
      prev_stall <= StallM;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n, input bit rv = 1'b0, input logic [31:0] rd = 32'h0);
    for (int i = 0; i < n; i++) begin
      MemReqM    = 1'b0;
      MemWriteM  = 1'b0;
      AddrM      = 32'h0;
      WriteDataM = 32'h0;
      mem_ready  = 1'b0;
      mem_rvalid = rv;
      mem_rdata  = rd;
      e_stall    = 1'b0;
      e_flush    = 1'b0;
      e_req      = 1'b0;
      e_fm       = 1'b0;
      step();
    end
  endtask

  // ready_at: REQ cycle (1-based) in which mem_ready is given, 0 = never.
  // rv_after: cycles after ready at which rvalid arrives, 0 = never.
  task automatic txn(input bit is_load, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input int ready_at, input int rv_after);
    int r_cyc, w_cyc, last;
    bit fault;
    if (!is_load) begin
      if (ready_at >= 1 && ready_at <= TO) begin
        r_cyc = ready_at; w_cyc = 0; fault = 1'b0;
      end else begin
        r_cyc = TO; w_cyc = 0; fault = 1'b1;
      end
    end else if (ready_at >= 1 && ready_at < TO) begin
      r_cyc = ready_at;
      if (rv_after >= 1 && ready_at + rv_after <= TO) begin
        w_cyc = rv_after; fault = 1'b0;
      end else begin
        w_cyc = TO - ready_at; fault = 1'b1;
      end
    end else begin
      r_cyc = TO; w_cyc = 0; fault = 1'b1;
    end
    last = r_cyc + w_cyc + 1;
    for (int c = 0; c <= last; c++) begin
      MemReqM    = 1'b1;
      MemWriteM  = !is_load;
      AddrM      = addr;
      WriteDataM = wdata;
      mem_ready  = (c >= 1) && (c <= r_cyc) && (c == ready_at);
      mem_rvalid = is_load && (rv_after >= 1) && (c == ready_at + rv_after) && (c <= r_cyc + w_cyc);
      mem_rdata  = mem_rvalid ? rdata : 32'hDEAD_BEEF;
      e_req      = (c >= 1) && (c <= r_cyc);
      e_stall    = (c < last);
      e_flush    = (c < last);
      e_fm       = (c == last) && fault;
      e_we       = !is_load;
      e_addr     = addr;
      e_wdata    = wdata;
      if (c == last) begin
        if (fault) rd_model = 32'h0;
        else if (is_load) rd_model = rdata;
        fs_model = fs_model | fault;
      end
      step();
    end
  endtask

  int s0, f0, q0;

  initial begin
    RST_N = 1'b1; MemReqM = 1'b0; MemWriteM = 1'b0; AddrM = 32'h0; WriteDataM = 32'h0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1 RST_N = 1'b0;
    #1;
    chk("rst_StallM", 32'(StallM), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_ReadDataM", ReadDataM, 32'h0);
    chk("rst_FaultSticky", 32'(FaultSticky), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    step();
    step();
    RST_N  = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Zero-wait load
    s0 = stall_total;
    txn(1'b1, 32'h0000_0100, 32'h0, 32'h1234_5678, 1, 1);
    chk("load_stall_len", 32'(stall_total - s0), 32'd3);
    chk("load_data", ReadDataM, 32'h1234_5678);
    chk("load_wb_capture", wb_q[wb_q.size()-1], 32'h1234_5678);
    idle(1);

    // Store with ready delayed 4 cycles
    s0 = stall_total;
    txn(1'b0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 5, 0);
    chk("store_stall_len", 32'(stall_total - s0), 32'd6);
    chk("store_keeps_rdata", ReadDataM, 32'h1234_5678);
    idle(1);

    // Back-to-back zero-wait loads
    s0 = stall_total;
    q0 = wb_q.size();
    txn(1'b1, 32'h0000_0200, 32'h0, 32'h1111_2222, 1, 1);
    txn(1'b1, 32'h0000_0204, 32'h0, 32'h3333_4444, 1, 1);
    chk("b2b_stall_len", 32'(stall_total - s0), 32'd6);
    chk("b2b_count", 32'(wb_q.size() - q0), 32'd2);
    if (wb_q.size() >= q0 + 2) begin
      chk("b2b_first", wb_q[q0], 32'h1111_2222);
      chk("b2b_second", wb_q[q0+1], 32'h3333_4444);
    end
    idle(1);

    // Load never answered: timeout
    s0 = stall_total;
    f0 = fault_total;
    txn(1'b1, 32'h0000_0300, 32'h0, 32'h7777_7777, 1, 0);
    chk("to_stall_len", 32'(stall_total - s0), 32'd9);
    chk("to_fault_pulse", 32'(fault_total - f0), 32'd1);
    chk("to_sticky", 32'(FaultSticky), 32'h1);
    chk("to_rdata_zero", ReadDataM, 32'h0);
    idle(2, 1'b1, 32'h5555_5555);
    chk("stale_rvalid", ReadDataM, 32'h0);
    idle(1);

    // Handshakes completing on the last allowed cycle
    s0 = stall_total;
    f0 = fault_total;
    txn(1'b1, 32'h0000_0400, 32'h0, 32'hA5A5_5A5A, 2, 6);
    chk("edge_load_stall", 32'(stall_total - s0), 32'd9);
    chk("edge_load_nofault", 32'(fault_total - f0), 32'd0);
    chk("edge_load_data", ReadDataM, 32'hA5A5_5A5A);
    s0 = stall_total;
    txn(1'b0, 32'h0000_0440, 32'h0102_0304, 32'h0, 8, 0);
    chk("edge_store_stall", 32'(stall_total - s0), 32'd9);
    chk("edge_store_nofault", 32'(fault_total - f0), 32'd0);
    idle(1);

    // Reset asserted while waiting for load data
    MemReqM = 1'b1; MemWriteM = 1'b0; AddrM = 32'h0000_0600; WriteDataM = 32'h0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    e_stall = 1'b1; e_flush = 1'b1; e_req = 1'b0; e_fm = 1'b0;
    step();
    mem_ready = 1'b1;
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h0000_0600; e_wdata = 32'h0;
    step();
    mem_ready = 1'b0;
    e_req = 1'b0;
    step();
    chk_en = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'h0);
    chk("midrst_StallM", 32'(StallM), 32'h0);
    chk("midrst_FlushW", 32'(FlushW), 32'h0);
    chk("midrst_ReadDataM", ReadDataM, 32'h0);
    chk("midrst_FaultSticky", 32'(FaultSticky), 32'h0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    rd_model = 32'h0;
    fs_model = 1'b0;
    step();
    RST_N  = 1'b1;
    chk_en = 1'b1;
    idle(1, 1'b1, 32'hBAD0_BAD0);
    idle(1);
    chk("post_rst_rvalid", ReadDataM, 32'h0);

    // Normal load after reset
    s0 = stall_total;
    txn(1'b1, 32'h0000_0500, 32'h0, 32'h0BAD_F00D, 2, 3);
    chk("post_rst_stall", 32'(stall_total - s0), 32'd6);
    chk("post_rst_data", ReadDataM, 32'h0BAD_F00D);
    idle(2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
